// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the decode-side hazard and forwarding controller.
//   RAW_DEF / DW_DEF : default register-address and data widths
//   fwd_src_e        : which source feeds a forwarded operand
package hazard_fwd_ctrl_pkg;

  localparam int RAW_DEF = 5;
  localparam int DW_DEF  = 32;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_EXE,
    FWD_WB,
    FWD_RF
  } fwd_src_e;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_mux.sv
// Priority operand select for one decode source register.
// Order: x0/disabled -> 0, execute result, write-back data, register file.
// Ports:
//   i_rs_en, i_rs        decode read enable and address
//   i_exe_rd_en/_rd/_rd_data  single-cycle execute result
//   i_wb_rd_en/_rd/_rd_data   write-back result
//   i_rf_data            register file read data
//   o_data               forwarded operand
module hazard_fwd_ctrl_fwd_mux
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int RAW = RAW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic           i_rs_en,
  input  logic [RAW-1:0] i_rs,
  input  logic           i_exe_rd_en,
  input  logic [RAW-1:0] i_exe_rd,
  input  logic [DW-1:0]  i_exe_rd_data,
  input  logic           i_wb_rd_en,
  input  logic [RAW-1:0] i_wb_rd,
  input  logic [DW-1:0]  i_wb_rd_data,
  input  logic [DW-1:0]  i_rf_data,
  output logic [DW-1:0]  o_data
);

  fwd_src_e sel;

  always_comb begin
    sel = FWD_RF;
    if (!i_rs_en || (i_rs == '0)) begin
      sel = FWD_ZERO;
    end else if (i_exe_rd_en && (i_exe_rd == i_rs)) begin
      sel = FWD_EXE;
    end else if (i_wb_rd_en && (i_wb_rd == i_rs)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    o_data = '0;
    unique case (sel)
      FWD_ZERO: o_data = '0;
      FWD_EXE:  o_data = i_exe_rd_data;
      FWD_WB:   o_data = i_wb_rd_data;
      FWD_RF:   o_data = i_rf_data;
      default:  o_data = '0;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Decode-side hazard and forwarding controller feeding the decode->execute
// register. Tracks in-flight long-latency writes (loads, divides) in a
// per-register scoreboard, holds decode on a read-after-write hit, and
// bypasses operands from execute, write-back or the register file.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_jump_valid               execute redirect; flushes decode, overrides hold
//   i_rs_1_en/_rs_1, i_rs_2_en/_rs_2   decode source reads
//   i_rd_en/_rd, i_long_op     decode destination and long-op marker
//   i_rf_rs_1_data/_rs_2_data  register file read data
//   i_exe_rd_en/_rd/_rd_data   single-cycle execute result
//   i_wb_rd_en/_rd/_rd_data, i_wb_long  write-back result
//   o_holding, o_flush         hold / flush to the pipeline register
//   o_rs_1_data, o_rs_2_data   forwarded operands
//   o_stall_timeout            sticky: a hold run reached STALL_MAX cycles
//   o_stall_cnt                saturating total of hold cycles
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int RAW       = RAW_DEF,
  parameter int DW        = DW_DEF,
  parameter int STALL_MAX = 64,
  parameter int CW        = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_jump_valid,
  input  logic           i_rs_1_en,
  input  logic [RAW-1:0] i_rs_1,
  input  logic           i_rs_2_en,
  input  logic [RAW-1:0] i_rs_2,
  input  logic           i_rd_en,
  input  logic [RAW-1:0] i_rd,
  input  logic           i_long_op,
  input  logic [DW-1:0]  i_rf_rs_1_data,
  input  logic [DW-1:0]  i_rf_rs_2_data,
  input  logic           i_exe_rd_en,
  input  logic [RAW-1:0] i_exe_rd,
  input  logic [DW-1:0]  i_exe_rd_data,
  input  logic           i_wb_rd_en,
  input  logic [RAW-1:0] i_wb_rd,
  input  logic [DW-1:0]  i_wb_rd_data,
  input  logic           i_wb_long,
  output logic           o_holding,
  output logic           o_flush,
  output logic [DW-1:0]  o_rs_1_data,
  output logic [DW-1:0]  o_rs_2_data,
  output logic           o_stall_timeout,
  output logic [CW-1:0]  o_stall_cnt
);

  localparam int NREG = 2 ** RAW;
  localparam int RUNW = $clog2(STALL_MAX + 1);
  localparam logic [RUNW-1:0] RUN_MAX = RUNW'(STALL_MAX);

  logic [NREG-1:0] sb_q, sb_d;
  logic [RUNW-1:0] run_q, run_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic wb_retire;
  logic hit_1, hit_2;
  logic issue;

  assign wb_retire = i_wb_rd_en && i_wb_long;

  // A long op completing this cycle resolves its hazard now: the data is
  // on the write-back bus and the mux forwards it.
  assign hit_1 = i_rs_1_en && (i_rs_1 != '0) && sb_q[i_rs_1] &&
                 !(wb_retire && (i_wb_rd == i_rs_1));
  assign hit_2 = i_rs_2_en && (i_rs_2 != '0) && sb_q[i_rs_2] &&
                 !(wb_retire && (i_wb_rd == i_rs_2));

  assign o_holding = (hit_1 || hit_2) && !i_jump_valid;
  assign o_flush   = i_jump_valid;

  assign issue = !o_holding && !i_jump_valid && i_rd_en && i_long_op &&
                 (i_rd != '0);

  always_comb begin
    sb_d = sb_q;
    if (wb_retire) begin
      sb_d[i_wb_rd] = 1'b0;
    end
    // Issue is applied after retire so a same-index collision leaves it set.
    if (issue) begin
      sb_d[i_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;

    run_d     = '0;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (o_holding) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (run_d == RUN_MAX) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q      <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sb_q      <= sb_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_stall_timeout = timeout_q;
  assign o_stall_cnt     = cnt_q;

  hazard_fwd_ctrl_fwd_mux #(.RAW(RAW), .DW(DW)) u_fwd_1 (
    .i_rs_en       (i_rs_1_en),
    .i_rs          (i_rs_1),
    .i_exe_rd_en   (i_exe_rd_en),
    .i_exe_rd      (i_exe_rd),
    .i_exe_rd_data (i_exe_rd_data),
    .i_wb_rd_en    (i_wb_rd_en),
    .i_wb_rd       (i_wb_rd),
    .i_wb_rd_data  (i_wb_rd_data),
    .i_rf_data     (i_rf_rs_1_data),
    .o_data        (o_rs_1_data)
  );

  hazard_fwd_ctrl_fwd_mux #(.RAW(RAW), .DW(DW)) u_fwd_2 (
    .i_rs_en       (i_rs_2_en),
    .i_rs          (i_rs_2),
    .i_exe_rd_en   (i_exe_rd_en),
    .i_exe_rd      (i_exe_rd),
    .i_exe_rd_data (i_exe_rd_data),
    .i_wb_rd_en    (i_wb_rd_en),
    .i_wb_rd       (i_wb_rd),
    .i_wb_rd_data  (i_wb_rd_data),
    .i_rf_data     (i_rf_rs_2_data),
    .o_data        (o_rs_2_data)
  );

endmodule
